muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the execute stage. Executes MULT, MULTU, DIV and DIVU over multiple cycles and raises busy so the hazard unit can stall dependent MFHI/MFLO.
- Supports MTHI/MTLO writes and pipeline-flush abort.
- Generalises the single-cycle ALU datapath to a configurable operand width with a start/busy/done handshake.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; sign correction is applied once when HI/LO are written.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_q, rneg_q, dz_pend_q;
  logic [WIDTH-1:0]   acc_q, q_q, b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dz_q;

  logic               a_neg_c, b_neg_c;
  logic [WIDTH-1:0]   a_mag_c, b_mag_c;
  logic [WIDTH:0]     sum_c, shifted_c;
  logic               ge_c;
  logic [WIDTH-1:0]   acc_d, q_d;
  logic [2*WIDTH-1:0] prod_raw_c, prod_c;
  logic [WIDTH-1:0]   hi_d, lo_d;

  // Operand magnitudes for signed ops
  always_comb begin
    a_neg_c = ~op_i[0] & src_a_i[WIDTH-1];
    b_neg_c = ~op_i[0] & src_b_i[WIDTH-1];
    a_mag_c = a_neg_c ? ((~src_a_i) + WIDTH'(1)) : src_a_i;
    b_mag_c = b_neg_c ? ((~src_b_i) + WIDTH'(1)) : src_b_i;
  end

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    sum_c     = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
    shifted_c = {acc_q, q_q[WIDTH-1]};
    ge_c      = (shifted_c >= {1'b0, b_q});
    if (is_div_q) begin
      acc_d = ge_c ? WIDTH'(shifted_c - {1'b0, b_q}) : shifted_c[WIDTH-1:0];
      q_d   = {q_q[WIDTH-2:0], ge_c};
    end else begin
      acc_d = sum_c[WIDTH:1];
      q_d   = {sum_c[0], q_q[WIDTH-1:1]};
    end
  end

  // Final sign-corrected HI/LO values
  always_comb begin
    prod_raw_c = {acc_q, q_q};
    prod_c     = neg_q ? ((~prod_raw_c) + (2*WIDTH)'(1)) : prod_raw_c;
    if (dz_pend_q) begin
      hi_d = q_q;
      lo_d = '1;
    end else if (is_div_q) begin
      hi_d = rneg_q ? ((~acc_q) + WIDTH'(1)) : acc_q;
      lo_d = neg_q ? ((~q_q) + WIDTH'(1)) : q_q;
    end else begin
      hi_d = prod_c[2*WIDTH-1:WIDTH];
      lo_d = prod_c[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_pend_q <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i && !flush_i) begin
            state_q  <= S_RUN;
            is_div_q <= op_i[1];
            neg_q    <= a_neg_c ^ b_neg_c;
            rneg_q   <= a_neg_c;
            acc_q    <= '0;
            b_q      <= b_mag_c;
            dz_q     <= 1'b0;
            // Divide by zero skips the iterations; q keeps the raw dividend for HI
            if (op_i[1] && (src_b_i == '0)) begin
              dz_pend_q <= 1'b1;
              cnt_q     <= '0;
              q_q       <= src_a_i;
              busy_q    <= 1'b0;
            end else begin
              dz_pend_q <= 1'b0;
              cnt_q     <= CNT_W'(WIDTH);
              q_q       <= a_mag_c;
              busy_q    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            acc_q  <= acc_d;
            q_q    <= q_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            busy_q <= (cnt_q != CNT_W'(1));
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (dz_pend_q) dz_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO, a monitor checks on done_o.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk_i, rst_i, start_i, flush_i, hi_we_i, lo_we_i;
  logic [1:0]   op_i;
  logic [W-1:0] src_a_i, src_b_i, wdata_i;
  logic         busy_o, done_o, div_by_zero_o;
  logic [W-1:0] hi_o, lo_o;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_by_zero_o(div_by_zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest expected result
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=1 expected no completion");
      end else begin
        e = exp_q.pop_front();
        chk("sb_hi", 64'(hi_o), 64'(e.hi));
        chk("sb_lo", 64'(lo_o), 64'(e.lo));
        chk("sb_dz", 64'(div_by_zero_o), 64'(e.dz));
      end
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit lo_wr);
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    if (lo_wr) begin lo_we_i = 1'b1; wdata_i = 32'hBEEF; end
    @(posedge clk_i); #1;
    start_i = 1'b0; lo_we_i = 1'b0;
  endtask

  // mode 0: plain; 1: disturb mid-run and write LO in the done cycle; 2: MTLO with start
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input int elat, input int ebusy, input int mode);
    exp_t e;
    int   n, bc;
    bit   seen;
    e.hi = ehi; e.lo = elo; e.dz = edz;
    exp_q.push_back(e);
    start_op(op, a, b, mode == 2);
    n = 0; bc = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk_i);
      if (n == 0) begin
        chk("dz_clear_on_start", 64'(div_by_zero_o), 64'(0));
        if (mode == 2) chk("lo_write_with_start", 64'(lo_o), 64'h BEEF);
      end
      if (busy_o) bc++;
      if (done_o) seen = 1'b1;
      else begin
        if (mode == 1) begin
          case (n)
            5: begin start_i = 1'b1; op_i = 2'b11; src_a_i = 32'd100; src_b_i = 32'd3; end
            6: start_i = 1'b0;
            8: begin lo_we_i = 1'b1; wdata_i = 32'hAAAA; end
            9: lo_we_i = 1'b0;
            default: ;
          endcase
        end
        n++;
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("latency", 64'(n), 64'(elat));
    chk("busy_cycles", 64'(bc), 64'(ebusy));
    if (mode == 1) begin lo_we_i = 1'b1; wdata_i = 32'hAAAA; end
    @(posedge clk_i); #1;
    lo_we_i = 1'b0;
    @(negedge clk_i);
    chk("done_single_pulse", 64'(done_o), 64'(0));
    if (mode == 1) chk("lo_write_in_done", 64'(lo_o), 64'h AAAA);
  endtask

  initial begin
    int d0;
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = 2'b00; src_a_i = '0; src_b_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_hi", 64'(hi_o), 64'(0));
    chk("rst_lo", 64'(lo_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_dz", 64'(div_by_zero_o), 64'(0));

    //     op     a             b             hi            lo            dz  lat busy mode
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33, 32, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 0, 33, 32, 0);
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, 32, 0);
    run_op(2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0, 33, 32, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 33, 32, 0);
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 33, 32, 0);
    run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 33, 32, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 33, 32, 0);
    run_op(2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1, 1, 0, 0);
    chk("dz_sticky", 64'(div_by_zero_o), 64'(1));
    run_op(2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 0, 33, 32, 0);

    // Flush mid-run keeps preloaded HI/LO and produces no completion
    @(posedge clk_i); #1 hi_we_i = 1'b1; wdata_i = 32'h1234;
    @(posedge clk_i); #1 hi_we_i = 1'b0; lo_we_i = 1'b1; wdata_i = 32'h5678;
    @(posedge clk_i); #1 lo_we_i = 1'b0;
    @(negedge clk_i);
    chk("mthi", 64'(hi_o), 64'h1234);
    chk("mtlo", 64'(lo_o), 64'h5678);
    d0 = done_cnt;
    start_op(2'b00, 32'd3, 32'd4, 1'b0);
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", 64'(busy_o), 64'(0));
    repeat (40) @(negedge clk_i);
    chk("flush_no_done", 64'(done_cnt), 64'(d0));
    chk("flush_hi", 64'(hi_o), 64'h1234);
    chk("flush_lo", 64'(lo_o), 64'h5678);

    // Reset mid-run clears everything
    start_op(2'b00, 32'd3, 32'd4, 1'b0);
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_hi", 64'(hi_o), 64'(0));
    chk("abort_lo", 64'(lo_o), 64'(0));
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_dz", 64'(div_by_zero_o), 64'(0));
    repeat (40) @(negedge clk_i);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));

    // Ignored mid-run start and MTLO, then MTLO in the done cycle; then MTLO with start
    run_op(2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 0, 33, 32, 1);
    run_op(2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 0, 33, 32, 2);

    repeat (40) @(negedge clk_i);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
